// File: rtl/rle_symbol_encoder.sv
// rle_symbol_encoder
//
// Run-length symbol encoder. It takes quantized coefficients in zigzag order,
// BLOCK_LEN per block with index 0 as the DC term. It produces JPEG-style
// (run, size, amplitude) symbols, including ZRL and EOB, for the Huffman
// lookup stage. Both sides use a valid/ready handshake, so back-pressure from
// the bit packer reaches the coefficient source.
//
// The only storage for symbols is the single output register. While ZRLs are
// being drained, one nonzero coefficient is also held.
//
// Optional feature: define RLE_SYMCNT_EN to add the sym_count[6:0] output.
// It gives the number of symbols emitted so far in the current block,
// counting the symbol presently on the output.
//
// rst_n is a synchronous, ACTIVE-HIGH reset. The name is historical.

module rle_symbol_encoder #(
  parameter int COEF_WIDTH = 12,
  parameter int BLOCK_LEN  = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [COEF_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [3:0]            out_run,
  output logic [3:0]            out_size,
  output logic [COEF_WIDTH-1:0] out_amp,
  output logic                  out_dc,
  output logic                  out_eob,
  output logic                  out_last
`ifdef RLE_SYMCNT_EN
  ,
  output logic [6:0]            sym_count
`endif
);

  localparam int IDX_W = (BLOCK_LEN > 2) ? $clog2(BLOCK_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_LEN - 1);
  localparam logic [5:0] ZRL_SPAN = 6'd16;

  typedef enum logic {
    ST_ACCEPT,
    ST_ZRL
  } state_t;

  state_t state, state_next;

  logic [IDX_W-1:0]      idx, idx_next;
  logic [5:0]            run, run_next;

  logic [3:0]            held_size, held_size_next;
  logic [COEF_WIDTH-1:0] held_amp, held_amp_next;
  logic                  held_last, held_last_next;

  logic                  nx_valid;
  logic [3:0]            nx_run;
  logic [3:0]            nx_size;
  logic [COEF_WIDTH-1:0] nx_amp;
  logic                  nx_dc;
  logic                  nx_eob;
  logic                  nx_last;
  logic                  sym_load;

  logic                  accept;
  logic                  consume;

  logic                  coef_neg;
  logic                  coef_zero;
  logic [COEF_WIDTH-1:0] coef_mag;
  logic [COEF_WIDTH-1:0] amp_mask;
  logic [3:0]            coef_size;
  logic [COEF_WIDTH-1:0] coef_amp;
  logic                  at_last;

  // Input is accepted only in ACCEPT and only while the output slot can take a result.
  assign in_ready = !rst_n && (state == ST_ACCEPT) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign consume  = out_valid && out_ready;
  assign at_last  = (idx == LAST_IDX);

  // Find the magnitude category and the amplitude bits of the incoming coefficient.
  always_comb begin
    coef_neg  = in_data[COEF_WIDTH-1];
    coef_zero = (in_data == '0);
    coef_mag  = coef_neg ? (~in_data + COEF_WIDTH'(1)) : in_data;
    coef_size = 4'd0;
    for (int i = 0; i < COEF_WIDTH; i++) begin
      if (coef_mag[i]) begin
        coef_size = 4'(i + 1);
      end
    end
    amp_mask = '0;
    for (int i = 0; i < COEF_WIDTH; i++) begin
      if (4'(i) < coef_size) begin
        amp_mask[i] = 1'b1;
      end
    end
    coef_amp = coef_neg ? ((in_data - COEF_WIDTH'(1)) & amp_mask) : in_data;
  end

  // Compute the next state, the position in the block, the run and the output register contents.
  always_comb begin
    state_next     = state;
    idx_next       = idx;
    run_next       = run;
    held_size_next = held_size;
    held_amp_next  = held_amp;
    held_last_next = held_last;
    nx_valid       = out_valid;
    nx_run         = out_run;
    nx_size        = out_size;
    nx_amp         = out_amp;
    nx_dc          = out_dc;
    nx_eob         = out_eob;
    nx_last        = out_last;
    sym_load       = 1'b0;

    case (state)
      ST_ACCEPT: begin
        if (consume) begin
          nx_valid = 1'b0;
        end
        if (accept) begin
          idx_next = at_last ? '0 : idx + IDX_W'(1);
          if (idx == '0) begin
            // A DC symbol is always emitted, even when the value is zero.
            sym_load = 1'b1;
            nx_valid = 1'b1;
            nx_run   = 4'd0;
            nx_size  = coef_size;
            nx_amp   = coef_amp;
            nx_dc    = 1'b1;
            nx_eob   = 1'b0;
            nx_last  = 1'b0;
            run_next = 6'd0;
          end else if (coef_zero) begin
            if (at_last) begin
              // A trailing zero run is replaced by EOB, with no ZRLs before it.
              sym_load = 1'b1;
              nx_valid = 1'b1;
              nx_run   = 4'd0;
              nx_size  = 4'd0;
              nx_amp   = '0;
              nx_dc    = 1'b0;
              nx_eob   = 1'b1;
              nx_last  = 1'b1;
              run_next = 6'd0;
            end else begin
              run_next = run + 6'd1;
            end
          end else if (run >= ZRL_SPAN) begin
            // Hold the coefficient, emit the first ZRL now, and drain the rest in ZRL.
            held_size_next = coef_size;
            held_amp_next  = coef_amp;
            held_last_next = at_last;
            sym_load       = 1'b1;
            nx_valid       = 1'b1;
            nx_run         = 4'd15;
            nx_size        = 4'd0;
            nx_amp         = '0;
            nx_dc          = 1'b0;
            nx_eob         = 1'b0;
            nx_last        = 1'b0;
            run_next       = run - ZRL_SPAN;
            state_next     = ST_ZRL;
          end else begin
            sym_load = 1'b1;
            nx_valid = 1'b1;
            nx_run   = run[3:0];
            nx_size  = coef_size;
            nx_amp   = coef_amp;
            nx_dc    = 1'b0;
            nx_eob   = 1'b0;
            nx_last  = at_last;
            run_next = 6'd0;
          end
        end
      end

      ST_ZRL: begin
        if (consume) begin
          sym_load = 1'b1;
          nx_valid = 1'b1;
          nx_dc    = 1'b0;
          nx_eob   = 1'b0;
          if (run >= ZRL_SPAN) begin
            nx_run   = 4'd15;
            nx_size  = 4'd0;
            nx_amp   = '0;
            nx_last  = 1'b0;
            run_next = run - ZRL_SPAN;
          end else begin
            nx_run     = run[3:0];
            nx_size    = held_size;
            nx_amp     = held_amp;
            nx_last    = held_last;
            run_next   = 6'd0;
            state_next = ST_ACCEPT;
          end
        end
      end

      default: begin
        state_next = ST_ACCEPT;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state <= ST_ACCEPT;
    end else begin
      state <= state_next;
    end
  end

  // Datapath registers. Reset discards any held coefficient and any undelivered symbol.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      idx       <= '0;
      run       <= 6'd0;
      held_size <= 4'd0;
      held_amp  <= '0;
      held_last <= 1'b0;
      out_valid <= 1'b0;
      out_run   <= 4'd0;
      out_size  <= 4'd0;
      out_amp   <= '0;
      out_dc    <= 1'b0;
      out_eob   <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      idx       <= idx_next;
      run       <= run_next;
      held_size <= held_size_next;
      held_amp  <= held_amp_next;
      held_last <= held_last_next;
      out_valid <= nx_valid;
      out_run   <= nx_run;
      out_size  <= nx_size;
      out_amp   <= nx_amp;
      out_dc    <= nx_dc;
      out_eob   <= nx_eob;
      out_last  <= nx_last;
    end
  end

`ifdef RLE_SYMCNT_EN
  logic [6:0] sym_cnt;

  // Count the symbols in the current block. Restart after the final symbol is taken.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      sym_cnt <= 7'd0;
    end else if (sym_load) begin
      sym_cnt <= (consume && out_last) ? 7'd1 : sym_cnt + 7'd1;
    end else if (consume && out_last) begin
      sym_cnt <= 7'd0;
    end
  end

  assign sym_count = sym_cnt;
`endif

endmodule

// File: tb/tb_rle_symbol_encoder.sv
// Testbench for rle_symbol_encoder with a scoreboard.
// Each block task pushes the symbols that a block-level reference model expects.
// A monitor process then pops and compares every symbol the encoder delivers.

module tb_rle_symbol_encoder;

  localparam int W = 12;
  localparam int N = 64;

  typedef struct {
    int run;
    int size;
    int amp;
    bit dc;
    bit eob;
    bit last;
    int cnt;
  } sym_t;

  typedef int block_t[N];

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [3:0]   out_run;
  logic [3:0]   out_size;
  logic [W-1:0] out_amp;
  logic         out_dc;
  logic         out_eob;
  logic         out_last;
`ifdef RLE_SYMCNT_EN
  logic [6:0]   sym_count;
`endif

  int   vectors     = 0;
  int   miscompares = 0;
  int   readyMode   = 0;
  int   stallCycles = 0;
  sym_t expQ[$];

  rle_symbol_encoder #(.COEF_WIDTH(W), .BLOCK_LEN(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_run   (out_run),
    .out_size  (out_size),
    .out_amp   (out_amp),
    .out_dc    (out_dc),
    .out_eob   (out_eob),
    .out_last  (out_last)
`ifdef RLE_SYMCNT_EN
    ,
    .sym_count (sym_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int sizeOf(input int v);
    int a = (v < 0) ? -v : v;
    int s = 0;
    while (a > 0) begin
      a = a >> 1;
      s++;
    end
    return s;
  endfunction

  function automatic int ampOf(input int v);
    int s = sizeOf(v);
    if (v >= 0) return v;
    return (v - 1) & ((1 << s) - 1);
  endfunction

  // Reference model: turn a whole block into its symbol list using JPEG RLE rules.
  task automatic modelBlock(input block_t blk);
    sym_t list[$];
    sym_t s;
    int   run = 0;
    for (int i = 0; i < N; i++) begin
      int v = blk[i];
      if (i == 0) begin
        s = '{0, sizeOf(v), ampOf(v), 1'b1, 1'b0, 1'b0, 0};
        list.push_back(s);
      end else if (v == 0) begin
        if (i == N - 1) begin
          s = '{0, 0, 0, 1'b0, 1'b1, 1'b1, 0};
          list.push_back(s);
        end else begin
          run++;
        end
      end else begin
        while (run >= 16) begin
          s = '{15, 0, 0, 1'b0, 1'b0, 1'b0, 0};
          list.push_back(s);
          run -= 16;
        end
        s = '{run, sizeOf(v), ampOf(v), 1'b0, 1'b0, (i == N - 1), 0};
        list.push_back(s);
        run = 0;
      end
    end
    for (int k = 0; k < list.size(); k++) begin
      s = list[k];
      s.cnt = k + 1;
      expQ.push_back(s);
    end
  endtask

  task automatic sendCoef(input int v);
    int waited = 0;
    in_valid = 1'b1;
    in_data  = v[W-1:0];
    forever begin
      @(negedge clk);
      if (in_ready) break;
      stallCycles++;
      waited++;
      if (waited > 300) begin
        checkOutput("in_ready_timeout", waited, 0);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic applyStimulus(input block_t blk);
    modelBlock(blk);
    for (int i = 0; i < N; i++) begin
      sendCoef(blk[i]);
    end
  endtask

  task automatic waitDrain();
    int n = 0;
    while (expQ.size() > 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    checkOutput("drain_pending", expQ.size(), 0);
  endtask

  function automatic int randCoef(input int pZero);
    int r;
    if ($urandom_range(0, 99) < pZero) return 0;
    r = $urandom_range(0, 9);
    if (r == 0) return -(1 << (W - 1));
    if (r <= 5) return ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 7)) : -int'($urandom_range(1, 7));
    return int'($urandom_range(0, (1 << W) - 1)) - (1 << (W - 1));
  endfunction

  // Downstream ready: always on, 50% random, or held low.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (readyMode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 1) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: compare every delivered symbol against the scoreboard, and check stability while stalled.
  initial begin
    bit   stalled = 1'b0;
    int   saved   = 0;
    int   cur;
    sym_t e;
    forever begin
      @(negedge clk);
      cur = int'({out_run, out_size, out_amp, out_dc, out_eob, out_last});
      if (rst_n !== 1'b0) begin
        stalled = 1'b0;
      end else if (out_valid) begin
        if (stalled) checkOutput("stable_fields", cur, saved);
        if (out_ready) begin
          checkOutput("symbol_expected", int'(expQ.size() > 0), 1);
          if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("run",  int'(out_run),  e.run);
            checkOutput("size", int'(out_size), e.size);
            checkOutput("amp",  int'(out_amp),  e.amp);
            checkOutput("dc",   int'(out_dc),   int'(e.dc));
            checkOutput("eob",  int'(out_eob),  int'(e.eob));
            checkOutput("last", int'(out_last), int'(e.last));
`ifdef RLE_SYMCNT_EN
            checkOutput("sym_count", int'(sym_count), e.cnt);
`endif
          end
          stalled = 1'b0;
        end else begin
          saved   = cur;
          stalled = 1'b1;
        end
      end else begin
        stalled = 1'b0;
      end
    end
  end

  initial begin
    block_t blk;
    int     p;

    rst_n    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_in_ready", int'(in_ready), 0);
    checkOutput("reset_out_valid", int'(out_valid), 0);
    checkOutput("reset_fields", int'({out_run, out_size, out_amp, out_dc, out_eob, out_last}), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("post_reset_in_ready", int'(in_ready), 1);
    checkOutput("post_reset_out_valid", int'(out_valid), 0);
    @(posedge clk);
    #1;

    // DC = -3, rest zero: a DC symbol followed by EOB.
    foreach (blk[i]) blk[i] = 0;
    blk[0] = -3;
    applyStimulus(blk);
    waitDrain();
    checkOutput("idle_after_eob", int'(out_valid), 0);

    // Sparse ACs with a negative value.
    foreach (blk[i]) blk[i] = 0;
    blk[0] = 5; blk[1] = 1; blk[3] = -1;
    applyStimulus(blk);
    waitDrain();

    // A 40-zero run needs two ZRLs, so in_ready drops for exactly two cycles.
    foreach (blk[i]) blk[i] = 0;
    blk[41] = 7;
    stallCycles = 0;
    applyStimulus(blk);
    waitDrain();
    checkOutput("zrl_stall_cycles", stallCycles, 2);

    // All ones: 64 symbols, the last marked last, no EOB.
    foreach (blk[i]) blk[i] = 1;
    applyStimulus(blk);
    waitDrain();

    // Final coefficient nonzero after a long run, plus the most-negative value.
    foreach (blk[i]) blk[i] = 0;
    blk[0] = -(1 << (W - 1)); blk[N-1] = -(1 << (W - 1));
    applyStimulus(blk);
    waitDrain();

    // Random blocks sent back to back with 50% downstream ready.
    readyMode = 1;
    for (int b = 0; b < 100; b++) begin
      p = $urandom_range(0, 100);
      foreach (blk[i]) blk[i] = randCoef(p);
      applyStimulus(blk);
    end
    waitDrain();
    readyMode = 0;
    repeat (2) @(posedge clk);
    #1;

    // Reset while ZRLs are pending, then send a fresh block.
    foreach (blk[i]) blk[i] = 0;
    blk[0] = 9; blk[20] = 5;
    expQ.push_back('{0, sizeOf(9), ampOf(9), 1'b1, 1'b0, 1'b0, 1});
    for (int i = 0; i < 20; i++) sendCoef(blk[i]);
    waitDrain();
    readyMode = 2;
    repeat (2) @(posedge clk);
    #1;
    sendCoef(blk[20]);
    @(negedge clk);
    checkOutput("zrl_in_ready_low", int'(in_ready), 0);
    checkOutput("zrl_out_valid", int'(out_valid), 1);
    checkOutput("zrl_run_field", int'(out_run), 15);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("mid_reset_in_ready", int'(in_ready), 0);
    @(negedge clk);
    checkOutput("mid_reset_out_valid", int'(out_valid), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    readyMode = 0;
    expQ.delete();
    @(negedge clk);
    checkOutput("after_reset_out_valid", int'(out_valid), 0);
    checkOutput("after_reset_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;
    foreach (blk[i]) blk[i] = 0;
    blk[0] = -6; blk[2] = 3; blk[30] = -100;
    applyStimulus(blk);
    waitDrain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rle_symbol_encoder.md
# rle_symbol_encoder

Run-length symbol encoder for the coder pipeline. Consumes quantized coefficients in zigzag order, one block of BLOCK_LEN per block, and emits JPEG-style (run, size, amplitude) symbols, including ZRL and EOB, to the entropy-coding stage downstream. Sits directly after the zigzag/delay-alignment registers and before the Huffman lookup. Uses a valid/ready handshake on both sides so that back-pressure from the bit packer propagates upstream.

## Interface
Parameters:
- COEF_WIDTH, 12, signed coefficient width; legal range 2..15.
- BLOCK_LEN, 64, coefficients per block; index 0 is DC; legal range 2..64.

Ports:
- clk  in  1  single clock; all logic is on its rising edge.
- rst_n  in  1  synchronous, active-high reset; the name is kept for codebase consistency.
- in_valid  in  1  coefficient present.
- in_ready  out  1  encoder accepts the coefficient this cycle.
- in_data  in  COEF_WIDTH  signed coefficient.
- out_valid  out  1  symbol present.
- out_ready  in  1  downstream accepts the symbol.
- out_run  out  4  count of zeros preceding the symbol.
- out_size  out  4  magnitude category.
- out_amp  out  COEF_WIDTH  amplitude bits, right-aligned, zero above size.
- out_dc  out  1  symbol is the block's DC term.
- out_eob  out  1  symbol is EOB.
- out_last  out  1  final symbol of the block.

## Operation
- Accept on in_valid && in_ready. Emit on out_valid && out_ready.
- idx counts from 0 to BLOCK_LEN-1 and wraps to 0 after the last coefficient. run (6 bits) counts consecutive zero ACs.
- **Size and amplitude.**
  - size = bit length of |v|; v=0 gives size 0.
  - v>0: amp = v.
  - v<0: amp = (v-1) masked to size bits.
  - Most-negative input: size = COEF_WIDTH.
- **DC (idx 0):** emit run=0, size/amp of v, out_dc=1, even if v=0.
- **AC zero, idx < BLOCK_LEN-1:** run++, no symbol.
- **AC nonzero:**
  - If run ≥ 16, emit ZRLs (run=15, size=0, amp=0) one at a time, subtracting 16 each, until run < 16.
  - Then emit (run, size, amp) and clear run.
- **AC at idx BLOCK_LEN-1:**
  - If v=0: discard pending run, emit EOB (run=0, size=0, out_eob=1, out_last=1). No ZRLs are emitted.
  - If v≠0: emit ZRLs as needed, then the symbol with out_last=1. No EOB follows.
- **States:**
  - ACCEPT: ready for a coefficient.
  - ZRL: a nonzero coefficient is held, ZRLs pending.
  - Transitions: ACCEPT→ZRL when a nonzero arrives with run ≥ 16. ZRL→ACCEPT when the last ZRL is accepted and the held symbol moves into the output register.
- in_ready = (state==ACCEPT) && (!out_valid || out_ready).
- Only the output register holds symbols, plus one held coefficient while in ZRL.

## Timing
- Reset values: out_valid=0, all out_* fields 0, in_ready=0 during reset and 1 on the first cycle after. idx=0, run=0, state=ACCEPT.
- Latency: a DC, nonzero AC, or final coefficient accepted at cycle t gives out_valid at t+1 when no ZRL is needed. Each pending ZRL adds one accepted-output cycle.
- Throughput: one coefficient per cycle with out_ready held high. in_ready drops only in ZRL or when the output register is stalled.
- Output fields are stable while out_valid && !out_ready.
- Block wrap: the coefficient after idx BLOCK_LEN-1 is DC of the next block. Back-to-back blocks need no idle cycle.
- Reset mid-block: any held coefficient and undelivered symbol are dropped; the next accepted coefficient is DC.

## Configuration
- RLE_SYMCNT_EN defined:
  - Adds output port sym_count[6:0], the number of symbols emitted so far in the current block, including the current one.
  - Valid alongside out_valid.
  - Resets to 0 after the out_last symbol is accepted and on reset.
- Undefined: the port and its counter are absent; all other behaviour is identical.

## Test plan
- DC=-3 followed by 63 zeros -> DC symbol (run 0, size 2, amp 2'b00, dc=1), then EOB with last=1; exactly 2 symbols.
- DC=5, AC[1]=1, AC[3]=-1, rest 0 -> (0,3,101,dc), (0,1,1), (1,1,0), EOB.
- DC=0, 40 zeros, AC[41]=7, rest 0 -> DC(0,0), ZRL, ZRL, (8,3,111), EOB. in_ready is low for 2 cycles.
- All 64 coefficients = 1 -> 64 symbols, the last with out_last=1 and no EOB. With RLE_SYMCNT_EN, sym_count=64 on the last symbol.
- Random out_ready (50%) over 100 random blocks -> symbol stream matches the reference model; fields are stable while stalled.
- Assert rst_n at idx 20 mid-ZRL, then send a fresh block -> out_valid=0 the cycle after reset; the new block starts with a DC symbol.
